// File: rtl/aes_if.sv
// ---------------------------------------------------------------------------
// aes_if -- request/result bundle for aes_core.
//
// Signals
//   start      master -> slave  request pulse, sampled only while the core is idle
//   mode       master -> slave  0 = encrypt, 1 = decrypt (sampled with start)
//   key        master -> slave  128-bit cipher key (sampled with start)
//   block_in   master -> slave  128-bit input block (sampled with start)
//   block_out  slave -> master  128-bit result, registered, held until next result/reset
//   done       slave -> master  one-cycle pulse coincident with a new block_out
//   dbg_state  slave -> master  current FSM state encoding, for observation only
//
// Handshake: start is a plain request strobe, not a valid/ready pair.  The core
// accepts it on a rising edge where it is idle and not pulsing done; any other
// start is dropped without effect.  done is the only completion indication.
// ---------------------------------------------------------------------------
interface aes_if;
    logic         start;
    logic         mode;
    logic [127:0] key;
    logic [127:0] block_in;
    logic [127:0] block_out;
    logic         done;
    logic [1:0]   dbg_state;

    modport master (
        output start, mode, key, block_in,
        input  block_out, done, dbg_state
    );

    modport slave (
        input  start, mode, key, block_in,
        output block_out, done, dbg_state
    );
endinterface

// File: rtl/aes_core.sv
// ---------------------------------------------------------------------------
// aes_core -- iterative AES-128 (FIPS-197), one round per clock, round keys
// generated on the fly from the previous round key.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   bus   aes_if.slave  start/mode/key/block_in in, block_out/done/dbg_state out
//
// Byte order: bits [127:120] are byte 0 = state[row 0][col 0]; bytes run
// column-major, so byte k sits at row k%4, column k/4.
//
// Configuration macro AES_DECRYPT_EN:
//   defined   -> encrypt and decrypt (mode selects)
//   undefined -> encrypt only, mode is ignored; no inverse datapath is built
//
// Timing (start sampled at edge 0):
//   encrypt: rounds 1..10 on edges 1..10, done high after edge 11
//   decrypt: forward key expansion on edges 1..10 (edge 10 also adds rk10),
//            inverse rounds on edges 11..20, done high after edge 21
// ---------------------------------------------------------------------------
module aes_core (
    input  logic clk,
    input  logic rst,
    aes_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_DONE   = 2'd2
`ifdef AES_DECRYPT_EN
        , ST_KEYEXP = 2'd3
`endif
    } state_t;

    // ---------------- GF(2^8) and S-box helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^-1 in GF(2^8)*, and 0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Round key i from round key i-1; rc is Rcon for round i.
    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubBytes, ShiftRows, MixColumns (unless last), AddRoundKey.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [16];
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) a[k] = sbox(s[127-8*k -: 8]);
        // Row r rotates left by r: out[r][c] = in[r][(c+r)%4].
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = a[4*((c+r)%4)+r];
        if (!last)
            for (int c = 0; c < 4; c++)
                o[127-32*c -: 32] = mix_col(o[127-32*c -: 32]);
        return o ^ rk;
    endfunction

`ifdef AES_DECRYPT_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Round key i-1 from round key i; rc is Rcon for round i.
    function automatic logic [127:0] key_prev(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]   ^ k[63:32];
        p2 = k[63:32]  ^ k[95:64];
        p1 = k[95:64]  ^ k[127:96];
        p0 = k[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (unless last).
    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] o;
        o = '0;
        // Row r rotates right by r: out[r][c] = in[r][(c-r)%4].
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        o = o ^ rk;
        if (!last)
            for (int c = 0; c < 4; c++)
                o[127-32*c -: 32] = inv_mix_col(o[127-32*c -: 32]);
        return o;
    endfunction
`endif

    // ---------------- State ----------------
    state_t       st_q,   st_d;
    logic [127:0] blk_q,  blk_d;    // working cipher state
    logic [127:0] key_q,  key_d;    // round key of the round just completed
    logic [3:0]   rnd_q,  rnd_d;    // round about to be computed
    logic [127:0] out_q,  out_d;
    logic         done_q, done_d;

    logic [127:0] rk_fwd;
    logic [127:0] enc_out;

    assign rk_fwd  = key_next(key_q, rcon(rnd_q));
    assign enc_out = enc_round(blk_q, rk_fwd, rnd_q == 4'd10);

`ifdef AES_DECRYPT_EN
    logic         mode_q, mode_d;
    logic [127:0] rk_inv;
    logic [127:0] dec_out;

    // In decrypt ROUND rnd_q counts 10 down to 1; Rcon(rnd_q) undoes the
    // expansion step that produced the key currently held in key_q.
    assign rk_inv  = key_prev(key_q, rcon(rnd_q));
    assign dec_out = dec_round(blk_q, rk_inv, rnd_q == 4'd1);
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
`endif

    always_comb begin
        st_d   = st_q;
        blk_d  = blk_q;
        key_d  = key_q;
        rnd_d  = rnd_q;
        out_d  = out_q;
        done_d = 1'b0;
`ifdef AES_DECRYPT_EN
        mode_d = mode_q;
`endif
        case (st_q)
            ST_IDLE: begin
                // done_q high means this is the completion cycle: start is ignored.
                if (bus.start && !done_q) begin
                    key_d = bus.key;
                    rnd_d = 4'd1;
`ifdef AES_DECRYPT_EN
                    mode_d = bus.mode;
                    if (bus.mode) begin
                        blk_d = bus.block_in;
                        st_d  = ST_KEYEXP;
                    end else begin
                        blk_d = bus.block_in ^ bus.key;
                        st_d  = ST_ROUND;
                    end
`else
                    blk_d = bus.block_in ^ bus.key;
                    st_d  = ST_ROUND;
`endif
                end
            end
`ifdef AES_DECRYPT_EN
            ST_KEYEXP: begin
                key_d = rk_fwd;
                if (rnd_q == 4'd10) begin
                    // rnd stays at 10 so the inverse schedule starts from Rcon(10).
                    blk_d = blk_q ^ rk_fwd;
                    st_d  = ST_ROUND;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
`endif
            ST_ROUND: begin
`ifdef AES_DECRYPT_EN
                if (mode_q) begin
                    blk_d = dec_out;
                    key_d = rk_inv;
                    if (rnd_q == 4'd1) begin
                        st_d  = ST_DONE;
                        rnd_d = 4'd0;
                    end else begin
                        rnd_d = rnd_q - 4'd1;
                    end
                end else
`endif
                begin
                    blk_d = enc_out;
                    key_d = rk_fwd;
                    if (rnd_q == 4'd10) begin
                        st_d  = ST_DONE;
                        rnd_d = 4'd0;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                out_d  = blk_q;
                done_d = 1'b1;
                // Drop key material once the result is out.
                blk_d  = '0;
                key_d  = '0;
`ifdef AES_DECRYPT_EN
                mode_d = 1'b0;
`endif
                st_d   = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            blk_q  <= '0;
            key_q  <= '0;
            rnd_q  <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
`ifdef AES_DECRYPT_EN
            mode_q <= 1'b0;
`endif
        end else begin
            st_q   <= st_d;
            blk_q  <= blk_d;
            key_q  <= key_d;
            rnd_q  <= rnd_d;
            out_q  <= out_d;
            done_q <= done_d;
`ifdef AES_DECRYPT_EN
            mode_q <= mode_d;
`endif
        end
    end

    assign bus.block_out = out_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = st_q;

endmodule

// File: tb/tb_aes_core.sv
// ---------------------------------------------------------------------------
// tb_aes_core -- bench for aes_core.  Expected results come from FIPS-197
// known answers and from a byte-array AES model (full key schedule computed
// up front, S-box generated from the 3 / 1/3 walk of GF(2^8)).
// ---------------------------------------------------------------------------
module tb_aes_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_if bus ();

    aes_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [127:0]  exp_q [$];
    logic [7:0]    sb  [256];
    logic [7:0]    isb [256];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

`ifdef AES_DECRYPT_EN
    localparam bit DEC_BUILD = 1'b1;
`else
    localparam bit DEC_BUILD = 1'b0;
`endif

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    task automatic build_sbox();
        int p, q, x;
        p = 1;
        q = 1;
        for (int i = 0; i < 255; i++) begin
            p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 255;
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            q = q & 255;
            if ((q & 'h80) != 0) q = q ^ 'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sb[p] = 8'(x ^ 'h63);
        end
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] din,
                                                input bit dec);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s  [4][4];
        logic [7:0]   tt [4][4];
        logic [7:0]   col [4];
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] o;
        int           rd;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = din[127-8*(4*c+r) -: 8];
        if (dec) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int step = 0; step <= 10; step++) begin
            rd = dec ? 10 - step : step;
            if (step > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        tt[r][c] = s[r][dec ? (c - r + 4) % 4 : (c + r) % 4];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        s[r][c] = dec ? isb[tt[r][c]] : sb[tt[r][c]];
                if (!dec && rd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) col[j] = s[j][c];
                        for (int r = 0; r < 4; r++) begin
                            acc = 8'h00;
                            for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j - r + 4) % 4], col[j]);
                            s[r][c] = acc;
                        end
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
            if (dec && step > 0 && rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) col[j] = s[j][c];
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j - r + 4) % 4], col[j]);
                        s[r][c] = acc;
                    end
                end
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- drivers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int lat_for(input logic m);
        return (DEC_BUILD && m) ? 21 : 11;
    endfunction

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] b,
                          input logic m, input logic [127:0] exp_blk,
                          input bit poke_busy, input bit poke_done);
        int           cyc;
        logic [127:0] want;
        logic [127:0] hold;
        exp_q.push_back(exp_blk);
        bus.start    = 1'b1;
        bus.mode     = m;
        bus.key      = k;
        bus.block_in = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.key      = rand128();
        bus.block_in = rand128();
        bus.mode     = 1'($urandom_range(0, 1));
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
            if (poke_busy) begin
                bus.start = (cyc == 4 || cyc == 9);
                bus.key   = rand128();
                bus.block_in = rand128();
            end
        end
        bus.start = 1'b0;
        check_eq({tag, " latency"}, 128'(cyc), 128'(lat_for(m)));
        want = exp_q.pop_front();
        check_eq({tag, " block_out"}, bus.block_out, want);
        hold = bus.block_out;
        if (poke_done) begin
            bus.start    = 1'b1;
            bus.mode     = 1'b0;
            bus.key      = rand128();
            bus.block_in = rand128();
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, " done_single"}, 128'(bus.done), 128'(0));
        check_eq({tag, " held"}, bus.block_out, hold);
    endtask

    task automatic watch_quiet(input string tag, input int n, input logic [127:0] hold);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check_eq({tag, " no_done"}, 128'(pulses), 128'(0));
        check_eq({tag, " out_hold"}, bus.block_out, hold);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] k, b, e;
        logic         m;
        build_sbox();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.key      = '0;
        bus.block_in = '0;
        repeat (3) @(negedge clk);
        check_eq("reset block_out", bus.block_out, '0);
        check_eq("reset done", 128'(bus.done), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Known answers, issued back to back.
        run_op("c1_enc", KEY_C1, PT_C1, 1'b0, CT_C1, 1'b0, 1'b0);
        run_op("appb_enc", KEY_B, PT_B, 1'b0, CT_B, 1'b0, 1'b0);
        run_op("zero_enc", '0, '0, 1'b0, CT_Z, 1'b0, 1'b0);
        run_op("c1_dec", KEY_C1, CT_C1, 1'b1, DEC_BUILD ? PT_C1 : ref_cipher(KEY_C1, CT_C1, 1'b0),
               1'b0, 1'b0);

        // start while busy and while done is high.
        run_op("busy_poke", KEY_C1, PT_C1, 1'b0, CT_C1, 1'b1, 1'b0);
        watch_quiet("busy_poke", 25, CT_C1);
        run_op("done_poke", KEY_B, PT_B, 1'b0, CT_B, 1'b0, 1'b1);
        watch_quiet("done_poke", 25, CT_B);

        // Reset in the middle of an encrypt.
        bus.start = 1'b1; bus.mode = 1'b0; bus.key = KEY_B; bus.block_in = PT_B;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort block_out", bus.block_out, '0);
        check_eq("abort done", 128'(bus.done), 128'(0));
        watch_quiet("abort", 25, '0);
        run_op("after_abort", KEY_C1, PT_C1, 1'b0, CT_C1, 1'b0, 1'b0);

        // Reset and start on the same edge.
        bus.start = 1'b1; bus.key = KEY_C1; bus.block_in = PT_C1; rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        watch_quiet("rst_start", 25, '0);

        // Random traffic against the model.
        for (int i = 0; i < 24; i++) begin
            k = rand128();
            b = rand128();
            m = 1'($urandom_range(0, 1));
            e = ref_cipher(k, b, DEC_BUILD && m);
            run_op(m ? "rand_dec" : "rand_enc", k, b, m, e, 1'b0, 1'b0);
        end
        // Model-derived ciphertext decrypted back (round trip).
        k = rand128();
        b = rand128();
        e = ref_cipher(k, b, 1'b0);
        run_op("rt_dec", k, e, 1'b1, DEC_BUILD ? b : ref_cipher(k, e, 1'b0), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
